// File: rtl/wb_resp_regs.sv
// Wishbone classic-cycle responder: four byte registers, TX/RX FIFOs, programmable wait states.
// Optional level interrupt (CSR[6] IE, irq_o) compiled in when WB_RESP_IRQ_EN is defined.
module wb_resp_regs #(
  parameter int ADDR_WIDTH = 2,
  parameter int DATA_WIDTH = 8,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  cyc_i,
  input  logic                  stb_i,
  input  logic                  we_i,
  input  logic [ADDR_WIDTH-1:0] adr_i,
  input  logic [DATA_WIDTH-1:0] dat_i,
  output logic                  ack_o,
  output logic [DATA_WIDTH-1:0] dat_o,
  output logic                  irq_o,
  input  logic                  tx_pop_i,
  output logic [DATA_WIDTH-1:0] tx_data_o,
  output logic                  tx_valid_o,
  input  logic                  rx_push_i,
  input  logic [DATA_WIDTH-1:0] rx_data_i,
  output logic                  rx_ready_o
);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_ACK} state_t;

  state_t                r_state;
  logic [3:0]            r_cnt;
  logic                  r_ack;
  logic [DATA_WIDTH-1:0] r_dat;
  logic                  r_en;
  logic [3:0]            r_wait;
  logic                  r_ovf, r_udf;
  logic [DATA_WIDTH-1:0] r_tx_mem [FIFO_DEPTH];
  logic [DATA_WIDTH-1:0] r_rx_mem [FIFO_DEPTH];
  logic [PW-1:0]         r_tx_rptr, r_tx_wptr, r_rx_rptr, r_rx_wptr;
  logic [CW-1:0]         r_tx_cnt, r_rx_cnt;

  logic                  w_req, w_go, w_ie;
  logic [1:0]            w_adr;
  logic                  w_tx_full, w_tx_empty, w_rx_full, w_rx_empty;
  logic                  w_data_acc, w_tx_try, w_tx_push, w_tx_pop;
  logic                  w_rx_try, w_rx_pop, w_rx_push;
  logic                  w_ovf_set, w_udf_set;
  logic [DATA_WIDTH-1:0] w_rdata;

  assign w_req      = cyc_i & stb_i;
  assign w_adr      = adr_i[1:0];
  // Side effects happen on the edge that moves the FSM into ACK.
  assign w_go       = w_req & (((r_state == S_IDLE) && (r_wait == 4'd0)) ||
                               ((r_state == S_WAIT) && (r_cnt == 4'd1)));

  assign w_tx_full  = (r_tx_cnt == CW'(FIFO_DEPTH));
  assign w_tx_empty = (r_tx_cnt == '0);
  assign w_rx_full  = (r_rx_cnt == CW'(FIFO_DEPTH));
  assign w_rx_empty = (r_rx_cnt == '0);

  assign w_data_acc = w_go & (w_adr == 2'd1) & r_en;
  assign w_tx_pop   = tx_pop_i & ~w_tx_empty;
  assign w_tx_try   = w_data_acc & we_i;
  assign w_tx_push  = w_tx_try & (~w_tx_full | w_tx_pop);
  assign w_rx_try   = w_data_acc & ~we_i;
  assign w_rx_pop   = w_rx_try & ~w_rx_empty;
  assign w_rx_push  = rx_push_i & (~w_rx_full | w_rx_pop);
  assign w_ovf_set  = (w_tx_try & ~w_tx_push) | (rx_push_i & ~w_rx_push);
  assign w_udf_set  = w_rx_try & w_rx_empty;

  always_comb begin
    w_rdata = '0;
    case (w_adr)
      2'd0:    w_rdata = DATA_WIDTH'({r_en, w_ie, w_tx_full, w_rx_empty, 4'b0000});
      2'd1:    if (r_en && !w_rx_empty) w_rdata = r_rx_mem[r_rx_rptr];
      2'd2:    w_rdata = DATA_WIDTH'({4'b0000, r_wait});
      default: w_rdata = DATA_WIDTH'({6'b000000, r_udf, r_ovf});
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_ack   <= 1'b0;
      r_dat   <= '0;
    end else begin
      r_ack <= 1'b0;
      if (w_go) r_dat <= we_i ? '0 : w_rdata;
      case (r_state)
        S_IDLE: if (w_req) begin
          r_cnt   <= r_wait;
          r_state <= (r_wait == 4'd0) ? S_ACK : S_WAIT;
        end
        S_WAIT: begin
          if (!w_req)              r_state <= S_IDLE;
          else if (r_cnt == 4'd1)  r_state <= S_ACK;
          else                     r_cnt   <= r_cnt - 4'd1;
        end
        default: begin
          r_ack   <= 1'b1;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_en      <= 1'b0;
      r_wait    <= '0;
      r_ovf     <= 1'b0;
      r_udf     <= 1'b0;
      r_tx_rptr <= '0;
      r_tx_wptr <= '0;
      r_tx_cnt  <= '0;
      r_rx_rptr <= '0;
      r_rx_wptr <= '0;
      r_rx_cnt  <= '0;
    end else begin
      if (w_go && we_i) begin
        case (w_adr)
          2'd0: r_en   <= dat_i[7];
          2'd2: r_wait <= dat_i[3:0];
          2'd3: begin
            if (dat_i[0]) r_ovf <= 1'b0;
            if (dat_i[1]) r_udf <= 1'b0;
          end
          default: ;
        endcase
      end
      // Sticky sets win over a same-edge clear.
      if (w_ovf_set) r_ovf <= 1'b1;
      if (w_udf_set) r_udf <= 1'b1;
      if (w_tx_push) r_tx_wptr <= r_tx_wptr + PW'(1);
      if (w_tx_pop)  r_tx_rptr <= r_tx_rptr + PW'(1);
      r_tx_cnt <= r_tx_cnt + CW'(w_tx_push) - CW'(w_tx_pop);
      if (w_rx_push) r_rx_wptr <= r_rx_wptr + PW'(1);
      if (w_rx_pop)  r_rx_rptr <= r_rx_rptr + PW'(1);
      r_rx_cnt <= r_rx_cnt + CW'(w_rx_push) - CW'(w_rx_pop);
    end
  end

  always_ff @(posedge clk_i) begin
    if (w_tx_push) r_tx_mem[r_tx_wptr] <= dat_i;
    if (w_rx_push) r_rx_mem[r_rx_wptr] <= rx_data_i;
  end

`ifdef WB_RESP_IRQ_EN
  logic r_ie, r_irq;
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_ie  <= 1'b0;
      r_irq <= 1'b0;
    end else begin
      if (w_go && we_i && (w_adr == 2'd0)) r_ie <= dat_i[6];
      r_irq <= r_ie & (~w_rx_empty | r_ovf | r_udf);
    end
  end
  assign w_ie  = r_ie;
  assign irq_o = r_irq;
`else
  assign w_ie  = 1'b0;
  assign irq_o = 1'b0;
`endif

  assign ack_o      = r_ack;
  assign dat_o      = r_dat;
  assign tx_valid_o = ~w_tx_empty;
  assign tx_data_o  = w_tx_empty ? '0 : r_tx_mem[r_tx_rptr];
  assign rx_ready_o = ~w_rx_full;
endmodule

// File: tb/tb_wb_resp_regs.sv
// Scoreboard bench for wb_resp_regs: bus tasks queue expected read data, a monitor checks on ack.
module tb_wb_resp_regs;
`ifdef WB_RESP_IRQ_EN
  localparam bit IRQ = 1'b1;
`else
  localparam bit IRQ = 1'b0;
`endif

  logic       clk_i = 0, rst_i = 1;
  logic       cyc_i = 0, stb_i = 0, we_i = 0;
  logic [1:0] adr_i = 0;
  logic [7:0] dat_i = 0, dat_o, tx_data_o, rx_data_i = 0;
  logic       ack_o, irq_o, tx_pop_i = 0, tx_valid_o, rx_push_i = 0, rx_ready_o;

  wb_resp_regs #(.ADDR_WIDTH(2), .DATA_WIDTH(8), .FIFO_DEPTH(4)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .cyc_i(cyc_i), .stb_i(stb_i), .we_i(we_i),
    .adr_i(adr_i), .dat_i(dat_i), .ack_o(ack_o), .dat_o(dat_o), .irq_o(irq_o),
    .tx_pop_i(tx_pop_i), .tx_data_o(tx_data_o), .tx_valid_o(tx_valid_o),
    .rx_push_i(rx_push_i), .rx_data_i(rx_data_i), .rx_ready_o(rx_ready_o));

  always #5 clk_i = ~clk_i;

  typedef struct { bit rd; logic [7:0] data; string nm; } exp_t;
  exp_t sb[$];
  int n_cmp = 0, n_err = 0, n_ack = 0;

  task automatic chk(input string nm, input int act, input int exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h @%0t", nm, act, exp, $time);
    end
  endtask

  // Monitor: every ack must match a queued transfer; reads compare dat_o.
  always @(negedge clk_i) begin
    if (!rst_i && ack_o === 1'b1) begin
      exp_t e;
      n_ack++;
      if (sb.size() == 0) chk("unexpected_ack", 1, 0);
      else begin
        e = sb.pop_front();
        if (e.rd) chk(e.nm, dat_o, e.data);
      end
    end
  end

  task automatic bus(input bit we, input logic [1:0] adr, input logic [7:0] d,
                     input logic [7:0] exp_rd, input int lat, input string nm);
    exp_t e;
    int cyc;
    e.rd = !we; e.data = exp_rd; e.nm = nm;
    sb.push_back(e);
    @(negedge clk_i);
    cyc_i = 1; stb_i = 1; we_i = we; adr_i = adr; dat_i = d;
    @(posedge clk_i);
    cyc = 0;
    do begin
      @(posedge clk_i); cyc++; #1;
    end while (ack_o !== 1'b1 && cyc < 40);
    cyc_i = 0; stb_i = 0;
    chk({nm, "_lat"}, cyc, lat);
    @(posedge clk_i); #1;
    chk({nm, "_ack1"}, ack_o, 0);
  endtask

  task automatic tpop(input logic [7:0] exp, input string nm);
    @(negedge clk_i);
    chk(nm, tx_data_o, exp);
    tx_pop_i = 1;
    @(posedge clk_i); #1;
    tx_pop_i = 0;
  endtask

  task automatic rpush(input logic [7:0] d);
    @(negedge clk_i);
    rx_push_i = 1; rx_data_i = d;
    @(posedge clk_i); #1;
    rx_push_i = 0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int acks;
    repeat (2) @(posedge clk_i); #1;
    chk("rst_ack", ack_o, 0); chk("rst_dat", dat_o, 0); chk("rst_irq", irq_o, 0);
    chk("rst_txv", tx_valid_o, 0); chk("rst_rxr", rx_ready_o, 1); chk("rst_txd", tx_data_o, 0);
    @(negedge clk_i); rst_i = 0;

    // CSR enable, zero wait states
    bus(1, 0, 8'h80, 0, 1, "wr_csr");
    bus(0, 0, 0, 8'h90, 1, "rd_csr");

    // three wait states
    bus(1, 2, 8'h03, 0, 1, "wr_wait3");
    bus(1, 1, 8'hA5, 0, 4, "wr_data_w3");
    #1 chk("txv_a5", tx_valid_o, 1);
    tpop(8'hA5, "txd_a5");
    chk("txv_popped", tx_valid_o, 0);
    bus(0, 2, 0, 8'h03, 4, "rd_wait3");
    bus(1, 2, 8'h00, 0, 4, "wr_wait0");

    // TX overflow
    for (int i = 1; i <= 5; i++) bus(1, 1, 8'(i), 0, 1, "wr_fill");
    bus(0, 0, 0, 8'hB0, 1, "rd_csr_txfull");
    bus(0, 3, 0, 8'h01, 1, "rd_stat_ovf");
    for (int i = 1; i <= 4; i++) tpop(8'(i), "txd_fill");
    chk("txv_drained", tx_valid_o, 0);
    bus(1, 3, 8'h01, 0, 1, "w1c_ovf");
    bus(0, 3, 0, 8'h00, 1, "rd_stat_clr");

    // interrupt, RX read and underflow
    bus(1, 0, 8'hC0, 0, 1, "wr_csr_ie");
    rpush(8'h3C);
    chk("irq_not_yet", irq_o, 0);
    @(posedge clk_i); #1;
    chk("irq_rx", irq_o, IRQ);
    bus(0, 1, 0, 8'h3C, 1, "rd_rx_3c");
    chk("irq_drop", irq_o, 0);
    bus(0, 1, 0, 8'h00, 1, "rd_rx_empty");
    chk("irq_udf", irq_o, IRQ);
    bus(0, 3, 0, 8'h02, 1, "rd_stat_udf");
    bus(0, 0, 0, IRQ ? 8'hD0 : 8'h90, 1, "rd_csr_ie");
    bus(1, 3, 8'h03, 0, 1, "w1c_all");

    // RX full and overflow
    rpush(8'h11); rpush(8'h22); rpush(8'h33); rpush(8'h44);
    chk("rxr_full", rx_ready_o, 0);
    rpush(8'h55);
    bus(0, 1, 0, 8'h11, 1, "rd_rx_11");
    chk("rxr_after_pop", rx_ready_o, 1);
    bus(0, 1, 0, 8'h22, 1, "rd_rx_22");
    bus(0, 1, 0, 8'h33, 1, "rd_rx_33");
    bus(0, 1, 0, 8'h44, 1, "rd_rx_44");
    bus(0, 3, 0, 8'h01, 1, "rd_stat_rxovf");
    bus(1, 3, 8'h03, 0, 1, "w1c_rxovf");

    // full TX: back-end pop and bus push on the same edge
    for (int i = 0; i < 4; i++) bus(1, 1, 8'hA0 + 8'(i), 0, 1, "wr_txa");
    begin
      exp_t e;
      e.rd = 0; e.data = 0; e.nm = "wr_same_edge";
      sb.push_back(e);
    end
    @(negedge clk_i);
    cyc_i = 1; stb_i = 1; we_i = 1; adr_i = 1; dat_i = 8'hA4; tx_pop_i = 1;
    @(posedge clk_i); #1; tx_pop_i = 0;
    @(posedge clk_i); #1;
    chk("same_edge_ack", ack_o, 1);
    cyc_i = 0; stb_i = 0;
    bus(0, 3, 0, 8'h00, 1, "rd_stat_same");
    bus(0, 0, 0, IRQ ? 8'hF0 : 8'hB0, 1, "rd_csr_same");
    for (int i = 1; i <= 4; i++) tpop(8'hA0 + 8'(i), "txd_same");

    // abort during wait states
    bus(1, 2, 8'h05, 0, 1, "wr_wait5");
    acks = n_ack;
    @(negedge clk_i);
    cyc_i = 1; stb_i = 1; we_i = 1; adr_i = 1; dat_i = 8'hEE;
    repeat (3) @(posedge clk_i);
    @(negedge clk_i); cyc_i = 0; stb_i = 0;
    repeat (10) @(posedge clk_i); #1;
    chk("abort_no_ack", n_ack, acks);
    chk("abort_txv", tx_valid_o, 0);

    // reset in the middle of a wait
    bus(1, 1, 8'h77, 0, 6, "wr_data_w5");
    bus(0, 2, 0, 8'h05, 6, "rd_wait5");
    rpush(8'h99);
    acks = n_ack;
    @(negedge clk_i);
    cyc_i = 1; stb_i = 1; we_i = 1; adr_i = 1; dat_i = 8'h66;
    @(posedge clk_i); @(posedge clk_i); #2;
    rst_i = 1; #1;
    chk("mrst_ack", ack_o, 0); chk("mrst_irq", irq_o, 0); chk("mrst_dat", dat_o, 0);
    chk("mrst_txv", tx_valid_o, 0); chk("mrst_rxr", rx_ready_o, 1); chk("mrst_txd", tx_data_o, 0);
    cyc_i = 0; stb_i = 0;
    @(posedge clk_i); @(negedge clk_i); rst_i = 0;
    chk("mrst_no_ack", n_ack, acks);
    bus(0, 0, 0, 8'h10, 1, "rd_csr_rst");
    bus(0, 2, 0, 8'h00, 1, "rd_wait_rst");
    bus(0, 1, 0, 8'h00, 1, "rd_data_dis");
    bus(0, 3, 0, 8'h00, 1, "rd_stat_dis");

    repeat (3) @(posedge clk_i); #1;
    chk("sb_empty", sb.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
